// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// It holds pc and fetches the word at pc over a req/ack handshake. It latches
// the fetched word for decode, then loads next_addr from the branch/jump logic.
// The unit also handles stall and HALT/resume.
//
// Optional feature: define PC_BRKPT_EN to add an address breakpoint
// (ports brk_en, brk_addr, brk_hit).
//
// Handshake: imem_req rises in FETCH and stays high, with imem_addr = pc held
// stable, until a cycle in which imem_ack is high. A transfer occurs on any
// posedge where imem_req && imem_ack. imem_data is taken only in that cycle.
// An ack outside FETCH is ignored.
module pc_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  next_addr,
  input  logic               stall,
  input  logic               resume,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic [4:0]         op,
  output logic               instr_vld,
  output logic               halted,
`ifdef PC_BRKPT_EN
  input  logic               brk_en,
  input  logic [ADDR_W-1:0]  brk_addr,
  output logic               brk_hit,
`endif
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 vld_q, vld_d;
  logic                 req_c;
  logic [5:0]           opcode;

`ifdef PC_BRKPT_EN
  logic brk_hit_q, brk_hit_d;
  // Set when resuming from a breakpoint so the refetch of brk_addr is let through once.
  logic bypass_q, bypass_d;
  logic brk_match;
  assign brk_match = brk_en && (pc_q == brk_addr) && !bypass_q;
  assign brk_hit   = brk_hit_q;
`endif

  assign opcode = instr_q[INSTR_W-1 -: 6];

  // State and datapath registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      vld_q   <= 1'b0;
`ifdef PC_BRKPT_EN
      brk_hit_q <= 1'b0;
      bypass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
`ifdef PC_BRKPT_EN
      brk_hit_q <= brk_hit_d;
      bypass_q  <= bypass_d;
`endif
    end
  end

  // Next-state, pc/instr update and fetch request.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = 1'b0;
    req_c   = 1'b0;
`ifdef PC_BRKPT_EN
    brk_hit_d = brk_hit_q;
    bypass_d  = bypass_q;
`endif
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
`ifdef PC_BRKPT_EN
        if (brk_match) begin
          state_d   = S_HALT;
          brk_hit_d = 1'b1;
        end else begin
          req_c = 1'b1;
          if (imem_ack) begin
            instr_d  = imem_data;
            vld_d    = 1'b1;
            bypass_d = 1'b0;
            state_d  = S_EXEC;
          end
        end
`else
        req_c = 1'b1;
        if (imem_ack) begin
          instr_d = imem_data;
          vld_d   = 1'b1;
          state_d = S_EXEC;
        end
`endif
      end
      S_EXEC: begin
        // HALT takes priority over stall.
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (!stall) begin
          pc_d    = next_addr;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_FETCH;
`ifdef PC_BRKPT_EN
          if (brk_hit_q) begin
            brk_hit_d = 1'b0;
            bypass_d  = 1'b1;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
`else
          pc_d = pc_q + ADDR_W'(1);
`endif
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign imem_req  = req_c;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[INSTR_W-1 -: 5];
  assign instr_vld = vld_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (default build, no breakpoint ports).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pc_fetch_unit;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic        clk;
  logic        rst;
  logic [7:0]  next_addr;
  logic        stall;
  logic        resume;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [4:0]  op;
  logic        instr_vld;
  logic        halted;
  logic [1:0]  dbg_state;

  int n_pass;
  int n_total;

  pc_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .next_addr (next_addr),
    .stall     (stall),
    .resume    (resume),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .pc        (pc),
    .instr     (instr),
    .op        (op),
    .instr_vld (instr_vld),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // Clock and run-time guard.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Serve one fetch at address a after dly wait cycles; returns at the
  // first EXEC cycle with next_addr driven to nxt.
  task automatic do_fetch(input logic [7:0] a, input int dly,
                          input logic [15:0] d, input logic [7:0] nxt);
    for (int i = 0; i < dly; i++) begin
      check("req_wait", 32'(imem_req), 32'd1);
      check("addr_wait", 32'(imem_addr), 32'(a));
      tick();
    end
    check("req", 32'(imem_req), 32'd1);
    check("addr", 32'(imem_addr), 32'(a));
    check("fetch_state", 32'(dbg_state), 32'(ST_FETCH));
    imem_ack  = 1'b1;
    imem_data = d;
    next_addr = nxt;
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'hDEAD;
    check("vld", 32'(instr_vld), 32'd1);
    check("instr", 32'(instr), 32'(d));
    check("req_exec", 32'(imem_req), 32'd0);
    check("exec_state", 32'(dbg_state), 32'(ST_EXEC));
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    next_addr = 8'h00;
    stall     = 1'b0;
    resume    = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    tick();
    tick();

    // Reset values.
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_op", 32'(op), 32'h0);
    check("rst_vld", 32'(instr_vld), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_BOOT));

    // BOOT -> FETCH one cycle after release, pc untouched.
    rst = 1'b0;
    tick();
    check("boot_pc", 32'(pc), 32'h00);

    // Same-cycle ack, then pc takes next_addr.
    do_fetch(8'h00, 0, 16'h1234, 8'h01);
    check("op_1234", 32'(op), 32'h02);
    tick();
    check("pc_01", 32'(pc), 32'h01);
    check("vld_one_cycle", 32'(instr_vld), 32'd0);

    // Two-cycle ack latency, next_addr sequence 01,02,05.
    do_fetch(8'h01, 2, 16'h0042, 8'h02);
    tick();
    check("pc_02", 32'(pc), 32'h02);
    do_fetch(8'h02, 2, 16'h0043, 8'h05);
    tick();
    check("pc_05", 32'(pc), 32'h05);
    do_fetch(8'h05, 2, 16'h0044, 8'hFF);
    tick();
    check("pc_ff", 32'(pc), 32'hFF);

    // Fetch at FF, next_addr 00 wraps to 00.
    do_fetch(8'hFF, 0, 16'h0045, 8'h00);
    tick();
    check("pc_wrap_na", 32'(pc), 32'h00);

    // Stall three cycles in EXEC: everything frozen, no request.
    do_fetch(8'h00, 0, 16'h0A5A, 8'h07);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(pc), 32'h00);
      check("stall_instr", 32'(instr), 32'h0A5A);
      check("stall_vld", 32'(instr_vld), 32'd0);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_state", 32'(dbg_state), 32'(ST_EXEC));
    end
    stall = 1'b0;
    tick();
    check("pc_07", 32'(pc), 32'h07);

    // HALT_OP at 07 with stall high at the same time: HALT wins, pc unchanged.
    do_fetch(8'h07, 1, 16'hFC00, 8'h33);
    check("op_halt", 32'(op), 32'h1F);
    stall = 1'b1;
    tick();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_pc", 32'(pc), 32'h07);
    tick();
    check("halt_stay", 32'(dbg_state), 32'(ST_HALT));
    check("halt_op_stable", 32'(op), 32'h1F);
    stall  = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_pc", 32'(pc), 32'h08);
    check("resume_halted", 32'(halted), 32'd0);

    // HALT at FF then resume wraps pc to 00.
    do_fetch(8'h08, 0, 16'h0011, 8'hFF);
    tick();
    do_fetch(8'hFF, 0, 16'hFC01, 8'h55);
    tick();
    check("halt_ff", 32'(halted), 32'd1);
    check("halt_ff_pc", 32'(pc), 32'hFF);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("wrap_pc", 32'(pc), 32'h00);

    // Reset asserted mid-FETCH, away from a clock edge; a late ack is ignored.
    do_fetch(8'h00, 0, 16'h2222, 8'h40);
    tick();
    check("pc_40", 32'(pc), 32'h40);
    #2;
    rst       = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 16'hFC00;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_pc", 32'(pc), 32'h00);
    check("async_instr", 32'(instr), 32'h0);
    check("async_state", 32'(dbg_state), 32'(ST_BOOT));
    tick();
    rst = 1'b0;
    tick();
    check("late_ack_vld", 32'(instr_vld), 32'd0);
    check("late_ack_instr", 32'(instr), 32'h0);
    check("late_ack_state", 32'(dbg_state), 32'(ST_FETCH));
    imem_ack = 1'b0;
    do_fetch(8'h00, 0, 16'h0100, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
